// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution: decides taken/not-taken, detects mispredicts, issues a
// registered one-cycle redirect to IF and maintains a PC-indexed 2-bit predictor table.
module branch_resolve_ctrl #(
   parameter int unsigned BHT_IDX_BITS = 6,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [31:0]          IF_PC,
   output logic                 IF_Pred_Taken,
   input  logic                 EX_Valid,
   input  logic                 EX_Branch,
   input  logic                 EX_Jump,
   input  logic [2:0]           EX_Funct3,
   input  logic [31:0]          EX_PC,
   input  logic [31:0]          EX_Target,
   input  logic                 EX_Pred_Taken,
   input  logic                 Stall,
   output logic                 Branch_Un_Ctrl,
   input  logic                 Branch_Equal,
   input  logic                 Branch_Lt,
   output logic                 Redirect_Valid,
   output logic [31:0]          Redirect_PC,
   output logic                 Illegal_Branch,
   output logic [CNT_WIDTH-1:0] Mispredict_Count
);

   localparam int unsigned BHT_ENTRIES = 1 << BHT_IDX_BITS;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr_t;

   ctr_t bht [BHT_ENTRIES];

   logic [BHT_IDX_BITS-1:0] if_idx;
   logic [BHT_IDX_BITS-1:0] ex_idx;
   logic                    res;
   logic                    legal;
   logic                    br_taken;
   logic                    taken;
   logic                    mispredict;
   logic                    bht_upd;
   ctr_t                    cur_ctr;
   ctr_t                    nxt_ctr;

   assign if_idx         = IF_PC[BHT_IDX_BITS+1:2];
   assign ex_idx         = EX_PC[BHT_IDX_BITS+1:2];
   assign IF_Pred_Taken  = bht[if_idx][1];
   assign Branch_Un_Ctrl = EX_Funct3[1];

   // An instruction in EX during a redirect cycle is wrong-path and is dropped.
   assign res = EX_Valid & ~Stall & ~Redirect_Valid;

   always_comb begin
      legal    = 1'b1;
      br_taken = 1'b0;
      case (EX_Funct3)
         3'b000:          br_taken = Branch_Equal;
         3'b001:          br_taken = ~Branch_Equal;
         3'b100, 3'b110:  br_taken = Branch_Lt;
         3'b101, 3'b111:  br_taken = ~Branch_Lt;
         default:         legal    = 1'b0;
      endcase
   end

   assign taken      = EX_Jump | (EX_Branch & br_taken);
   assign mispredict = taken != EX_Pred_Taken;
   assign bht_upd    = res & EX_Branch & ~EX_Jump & legal;
   assign cur_ctr    = bht[ex_idx];

   always_comb begin
      nxt_ctr = cur_ctr;
      if (taken && cur_ctr != STRONG_T)
         nxt_ctr = ctr_t'(cur_ctr + 2'd1);
      else if (!taken && cur_ctr != STRONG_NT)
         nxt_ctr = ctr_t'(cur_ctr - 2'd1);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int unsigned i = 0; i < BHT_ENTRIES; i++)
            bht[i] <= WEAK_NT;
         Redirect_Valid   <= 1'b0;
         Redirect_PC      <= '0;
         Illegal_Branch   <= 1'b0;
         Mispredict_Count <= '0;
      end else begin
         Redirect_Valid <= res & mispredict;
         Illegal_Branch <= res & EX_Branch & ~EX_Jump & ~legal;
         // Count moves with the redirect so it already includes the pulse being shown.
         if (res && mispredict) begin
            Redirect_PC <= taken ? EX_Target : EX_PC + 32'd4;
            if (Mispredict_Count != '1)
               Mispredict_Count <= Mispredict_Count + 1'b1;
         end
         if (bht_upd)
            bht[ex_idx] <= nxt_ctr;
      end
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with hand-computed expectations.
module tb_branch_resolve_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] IF_PC;
   logic        IF_Pred_Taken;
   logic        EX_Valid, EX_Branch, EX_Jump;
   logic [2:0]  EX_Funct3;
   logic [31:0] EX_PC, EX_Target;
   logic        EX_Pred_Taken, Stall;
   logic        Branch_Un_Ctrl, Branch_Equal, Branch_Lt;
   logic        Redirect_Valid;
   logic [31:0] Redirect_PC;
   logic        Illegal_Branch;
   logic [15:0] Mispredict_Count;

   int tests = 0;
   int fails = 0;

   branch_resolve_ctrl #(.BHT_IDX_BITS(6), .CNT_WIDTH(16)) dut (
      .Clk(Clk), .Reset(Reset), .IF_PC(IF_PC), .IF_Pred_Taken(IF_Pred_Taken),
      .EX_Valid(EX_Valid), .EX_Branch(EX_Branch), .EX_Jump(EX_Jump),
      .EX_Funct3(EX_Funct3), .EX_PC(EX_PC), .EX_Target(EX_Target),
      .EX_Pred_Taken(EX_Pred_Taken), .Stall(Stall), .Branch_Un_Ctrl(Branch_Un_Ctrl),
      .Branch_Equal(Branch_Equal), .Branch_Lt(Branch_Lt),
      .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC),
      .Illegal_Branch(Illegal_Branch), .Mispredict_Count(Mispredict_Count)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      EX_Valid = 0; EX_Branch = 0; EX_Jump = 0; EX_Funct3 = 3'b000;
      EX_PC = '0; EX_Target = '0; EX_Pred_Taken = 0; Stall = 0;
      Branch_Equal = 0; Branch_Lt = 0;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic eq, input logic lt, input logic pred);
      EX_Valid = 1; EX_Branch = 1; EX_Jump = 0; EX_Funct3 = f3;
      EX_PC = pc; EX_Target = tgt; Branch_Equal = eq; Branch_Lt = lt;
      EX_Pred_Taken = pred; Stall = 0;
   endtask

   task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
      IF_PC = pc;
      #1;
      check(tag, {31'b0, IF_Pred_Taken}, {31'b0, exp});
   endtask

   initial begin
      idle();
      IF_PC = '0;
      Reset = 1;
      tick(); tick();
      Reset = 0;
      check("rst_rv", {31'b0, Redirect_Valid}, 32'd0);
      check("rst_rpc", Redirect_PC, 32'd0);
      check("rst_cnt", {16'b0, Mispredict_Count}, 32'd0);
      check("rst_ill", {31'b0, Illegal_Branch}, 32'd0);
      pred_at("rst_pred40", 32'h40, 1'b0);
      pred_at("rst_pred100", 32'h100, 1'b0);

      // BLT taken, predicted not-taken
      br(3'b100, 32'h100, 32'h80, 0, 1, 0);
      #1 check("blt_unctrl", {31'b0, Branch_Un_Ctrl}, 32'd0);
      tick(); idle();
      check("blt_rv", {31'b0, Redirect_Valid}, 32'd1);
      check("blt_rpc", Redirect_PC, 32'h80);
      check("blt_cnt", {16'b0, Mispredict_Count}, 32'd1);
      pred_at("blt_pred", 32'h100, 1'b1);
      tick();
      check("blt_rv_off", {31'b0, Redirect_Valid}, 32'd0);
      check("blt_rpc_hold", Redirect_PC, 32'h80);

      // BGEU not taken, predicted taken; index 0 goes 10 -> 01
      br(3'b111, 32'h200, 32'h300, 0, 1, 1);
      #1 check("bgeu_unctrl", {31'b0, Branch_Un_Ctrl}, 32'd1);
      tick(); idle();
      check("bgeu_rv", {31'b0, Redirect_Valid}, 32'd1);
      check("bgeu_rpc", Redirect_PC, 32'h204);
      check("bgeu_cnt", {16'b0, Mispredict_Count}, 32'd2);
      pred_at("bgeu_pred", 32'h200, 1'b0);
      tick();
      // correct not-taken: 01 -> 00
      br(3'b111, 32'h200, 32'h300, 0, 1, 0);
      tick(); idle();
      check("bgeu2_rv", {31'b0, Redirect_Valid}, 32'd0);
      // taken BEQ from 00 -> 01, still predicts not-taken
      br(3'b000, 32'h200, 32'h280, 1, 0, 0);
      tick(); idle();
      check("beq0_rpc", Redirect_PC, 32'h280);
      check("beq0_cnt", {16'b0, Mispredict_Count}, 32'd3);
      pred_at("sat_low_pred", 32'h200, 1'b0);
      tick();

      // BEQ x4 at 0x40, taken, predicted taken; same-index read sees pre-update value
      br(3'b000, 32'h40, 32'h10, 1, 0, 1);
      pred_at("bypass_pre", 32'h40, 1'b0);
      tick();
      pred_at("beq1_pred", 32'h40, 1'b1);
      tick(); tick(); tick(); idle();
      check("beq4_rv", {31'b0, Redirect_Valid}, 32'd0);
      check("beq4_cnt", {16'b0, Mispredict_Count}, 32'd3);
      pred_at("beq4_pred", 32'h40, 1'b1);
      // BNE not taken, predicted taken: 11 -> 10
      br(3'b001, 32'h40, 32'h10, 1, 0, 1);
      tick(); idle();
      check("bne_rpc", Redirect_PC, 32'h44);
      check("bne_cnt", {16'b0, Mispredict_Count}, 32'd4);
      pred_at("bne_pred", 32'h40, 1'b1);
      tick();
      // 10 -> 01 proves the counter had saturated at 11
      br(3'b001, 32'h40, 32'h10, 1, 0, 0);
      tick(); idle();
      pred_at("sat_high_pred", 32'h40, 1'b0);

      // JAL (branch bit also set, branch would be not-taken) then wrong-path BLT
      br(3'b000, 32'h40, 32'h1000, 0, 0, 0);
      EX_Jump = 1;
      tick();
      br(3'b100, 32'h40, 32'h2000, 0, 1, 0);
      check("jal_rv", {31'b0, Redirect_Valid}, 32'd1);
      check("jal_rpc", Redirect_PC, 32'h1000);
      check("jal_cnt", {16'b0, Mispredict_Count}, 32'd5);
      tick(); idle();
      check("wrongpath_rv", {31'b0, Redirect_Valid}, 32'd0);
      check("wrongpath_cnt", {16'b0, Mispredict_Count}, 32'd5);
      check("wrongpath_rpc", Redirect_PC, 32'h1000);
      pred_at("jal_no_upd", 32'h40, 1'b0);

      // Illegal funct3 010
      br(3'b010, 32'h40, 32'h10, 1, 1, 0);
      tick(); idle();
      check("ill_rv", {31'b0, Redirect_Valid}, 32'd0);
      check("ill_flag", {31'b0, Illegal_Branch}, 32'd1);
      tick();
      check("ill_flag_off", {31'b0, Illegal_Branch}, 32'd0);

      // PC+4 wrap
      br(3'b001, 32'hFFFF_FFFC, 32'h10, 1, 0, 1);
      tick(); idle();
      check("wrap_rv", {31'b0, Redirect_Valid}, 32'd1);
      check("wrap_rpc", Redirect_PC, 32'h0);
      check("wrap_cnt", {16'b0, Mispredict_Count}, 32'd6);
      tick();

      // Stall blocks resolution and table update
      br(3'b100, 32'h40, 32'h2000, 0, 1, 0);
      Stall = 1;
      tick(); idle();
      check("stall_rv", {31'b0, Redirect_Valid}, 32'd0);
      check("stall_cnt", {16'b0, Mispredict_Count}, 32'd6);
      pred_at("stall_pred", 32'h40, 1'b0);

      // A registered redirect still pulses under stall
      br(3'b100, 32'h300, 32'h80, 0, 1, 0);
      tick(); idle();
      Stall = 1;
      check("stallpend_rv", {31'b0, Redirect_Valid}, 32'd1);
      check("stallpend_cnt", {16'b0, Mispredict_Count}, 32'd7);
      tick(); idle();

      // Reset with a redirect pending and a resolution in the reset cycle
      br(3'b000, 32'h600, 32'h700, 1, 0, 0);
      tick();
      check("prerst_rv", {31'b0, Redirect_Valid}, 32'd1);
      br(3'b000, 32'h40, 32'h700, 1, 0, 0);
      Reset = 1;
      tick(); idle();
      Reset = 0;
      check("rst2_rv", {31'b0, Redirect_Valid}, 32'd0);
      check("rst2_rpc", Redirect_PC, 32'h0);
      check("rst2_cnt", {16'b0, Mispredict_Count}, 32'd0);
      pred_at("rst2_pred", 32'h300, 1'b0);
      tick();
      check("rst2_discard", {31'b0, Redirect_Valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
